soc_reset_sequencer: RTL and testbench

SOC_RESET_SEQUENCER -- requirements
Module: soc_reset_sequencer

---
 rtl/soc_reset_pkg.sv | 20 ++
 rtl/soc_bit_sync.sv | 24 ++
 rtl/soc_reset_sequencer.sv | 140 ++++++++++++++
 tb/tb_soc_reset_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_reset_pkg.sv
// Shared types and constants for the SoC reset sequencer.
package soc_reset_pkg;

    localparam int unsigned CntWidth = 16;

    typedef enum logic [2:0] {
        StWaitSupply = 3'd0,
        StStretch    = 3'd1,
        StRelPo      = 3'd2,
        StRun        = 3'd3,
        StSwRst      = 3'd4
    } rst_state_e;

    typedef enum logic [1:0] {
        CausePor      = 2'b00,
        CauseBrownOut = 2'b01,
        CauseSw       = 2'b10
    } rst_cause_e;

endpackage

// File: rtl/soc_bit_sync.sv
// Multi-flop single-bit synchroniser with async active-low reset to a chosen value.
module soc_bit_sync #(
    parameter int unsigned Stages     = 2,
    parameter logic        ResetValue = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {Stages{ResetValue}};
        end else begin
            sync_q <= {sync_q[Stages-2:0], d};
        end
    end

    assign q = sync_q[Stages-1];

endmodule

// File: rtl/soc_reset_sequencer.sv
// Power-on / brown-out / software reset sequencer: stretches reset after supply and pad
// reset are valid, then releases the always-on reset followed by the system reset.
module soc_reset_sequencer
    import soc_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned GAP_CYCLES     = 4
) (
    input  logic       CLK,
    input  logic       PORESETn,
    input  logic       SUPPLY_OK,
    input  logic       SWRESETREQ,
    output logic       SYS_PORESETn,
    output logic       SYS_HRESETn,
    output logic [2:0] RST_STATE,
    output logic [1:0] RST_CAUSE
);

    localparam logic [CntWidth-1:0] StretchLast = CntWidth'(STRETCH_CYCLES - 1);
    localparam logic [CntWidth-1:0] GapLast     = CntWidth'(GAP_CYCLES - 1);

    logic por_sync;
    logic sup_sync;

    rst_state_e          state_q, state_d;
    rst_cause_e          cause_q, cause_d;
    logic [CntWidth-1:0] cnt_q, cnt_d, cnt_sat;
    logic                poresetn_q, poresetn_d;
    logic                hresetn_q, hresetn_d;

    // Pad reset release is shifted in as a constant 1 behind the async reset.
    soc_bit_sync #(
        .Stages     (SYNC_STAGES),
        .ResetValue (1'b0)
    ) u_por_sync (
        .clk   (CLK),
        .rst_n (PORESETn),
        .d     (1'b1),
        .q     (por_sync)
    );

    soc_bit_sync #(
        .Stages     (SYNC_STAGES),
        .ResetValue (1'b0)
    ) u_sup_sync (
        .clk   (CLK),
        .rst_n (PORESETn),
        .d     (SUPPLY_OK),
        .q     (sup_sync)
    );

    assign cnt_sat = (cnt_q == {CntWidth{1'b1}}) ? cnt_q : cnt_q + CntWidth'(1);

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        cnt_d      = cnt_sat;
        poresetn_d = poresetn_q;
        hresetn_d  = hresetn_q;

        // Brown-out wins over every other transition.
        if (state_q != StWaitSupply && !sup_sync) begin
            state_d    = StWaitSupply;
            cause_d    = CauseBrownOut;
            cnt_d      = '0;
            poresetn_d = 1'b0;
            hresetn_d  = 1'b0;
        end else begin
            unique case (state_q)
                StWaitSupply: begin
                    cnt_d      = '0;
                    poresetn_d = 1'b0;
                    hresetn_d  = 1'b0;
                    if (por_sync && sup_sync) begin
                        state_d = StStretch;
                    end
                end
                StStretch: begin
                    if (cnt_q >= StretchLast) begin
                        state_d    = StRelPo;
                        cnt_d      = '0;
                        poresetn_d = 1'b1;
                    end
                end
                StRelPo: begin
                    if (cnt_q >= GapLast) begin
                        state_d   = StRun;
                        cnt_d     = '0;
                        hresetn_d = 1'b1;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                    if (SWRESETREQ) begin
                        state_d   = StSwRst;
                        cause_d   = CauseSw;
                        hresetn_d = 1'b0;
                    end
                end
                StSwRst: begin
                    // Saturating counter keeps a long-held request from wrapping the compare.
                    if (cnt_q >= StretchLast && !SWRESETREQ) begin
                        state_d   = StRun;
                        cnt_d     = '0;
                        hresetn_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = StWaitSupply;
                    cnt_d      = '0;
                    poresetn_d = 1'b0;
                    hresetn_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state_q    <= StWaitSupply;
            cause_q    <= CausePor;
            cnt_q      <= '0;
            poresetn_q <= 1'b0;
            hresetn_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
            poresetn_q <= poresetn_d;
            hresetn_q  <= hresetn_d;
        end
    end

    assign SYS_PORESETn = poresetn_q;
    assign SYS_HRESETn  = hresetn_q;
    assign RST_STATE    = state_q;
    assign RST_CAUSE    = cause_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against an elapsed-time model.
module tb_soc_reset_sequencer;

    localparam int unsigned Sync = 2;
    localparam int unsigned S    = 16;
    localparam int unsigned G    = 4;

    logic       CLK;
    logic       PORESETn;
    logic       SUPPLY_OK;
    logic       SWRESETREQ;
    logic       SYS_PORESETn;
    logic       SYS_HRESETn;
    logic [2:0] RST_STATE;
    logic [1:0] RST_CAUSE;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned edge_n  = 0;

    // Model: elapsed edges since the sequence started, plus a software-reset window.
    int unsigned m_edges;
    bit          sup_pipe [Sync];
    bit          m_seq;
    int unsigned m_t;
    bit          m_sw;
    int unsigned m_sw_t;
    int unsigned m_cause;

    soc_reset_sequencer #(
        .SYNC_STAGES    (Sync),
        .STRETCH_CYCLES (S),
        .GAP_CYCLES     (G)
    ) dut (
        .CLK          (CLK),
        .PORESETn     (PORESETn),
        .SUPPLY_OK    (SUPPLY_OK),
        .SWRESETREQ   (SWRESETREQ),
        .SYS_PORESETn (SYS_PORESETn),
        .SYS_HRESETn  (SYS_HRESETn),
        .RST_STATE    (RST_STATE),
        .RST_CAUSE    (RST_CAUSE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_edges = 0;
        for (int i = 0; i < Sync; i++) sup_pipe[i] = 1'b0;
        m_seq   = 1'b0;
        m_t     = 0;
        m_sw    = 1'b0;
        m_sw_t  = 0;
        m_cause = 0;
    endfunction

    function automatic void model_edge();
        bit sup_s;
        bit por_s;
        if (!PORESETn) begin
            model_reset();
            return;
        end
        sup_s = sup_pipe[Sync-1];
        por_s = (m_edges >= Sync);
        if (m_seq && !sup_s) begin
            m_seq   = 1'b0;
            m_sw    = 1'b0;
            m_cause = 1;
        end else if (!m_seq) begin
            if (por_s && sup_s) begin
                m_seq = 1'b1;
                m_t   = 0;
            end
        end else if (m_sw) begin
            if (m_sw_t < 100000) m_sw_t++;
            if (m_sw_t >= S && !SWRESETREQ) m_sw = 1'b0;
        end else if (m_t >= S + G && SWRESETREQ) begin
            m_sw    = 1'b1;
            m_sw_t  = 0;
            m_cause = 2;
        end else if (m_t < 100000) begin
            m_t++;
        end
        for (int i = Sync - 1; i > 0; i--) sup_pipe[i] = sup_pipe[i-1];
        sup_pipe[0] = SUPPLY_OK;
        if (m_edges < 1000) m_edges++;
    endfunction

    function automatic int unsigned exp_po();
        return (m_seq && m_t >= S) ? 1 : 0;
    endfunction

    function automatic int unsigned exp_h();
        return (m_seq && !m_sw && m_t >= S + G) ? 1 : 0;
    endfunction

    function automatic int unsigned exp_state();
        if (!m_seq) return 0;
        if (m_sw) return 4;
        if (m_t < S) return 1;
        if (m_t < S + G) return 2;
        return 3;
    endfunction

    task automatic step();
        @(posedge CLK);
        model_edge();
        edge_n++;
        #1;
        check_eq("sys_poresetn", 32'(SYS_PORESETn), exp_po());
        check_eq("sys_hresetn", 32'(SYS_HRESETn), exp_h());
        check_eq("rst_state", 32'(RST_STATE), exp_state());
        check_eq("rst_cause", 32'(RST_CAUSE), m_cause);
    endtask

    task automatic assert_por();
        PORESETn = 1'b0;
        model_reset();
    endtask

    initial begin
        int unsigned low_cnt;
        int unsigned k;
        int unsigned r;

        PORESETn   = 1'b0;
        SUPPLY_OK  = 1'b1;
        SWRESETREQ = 1'b0;
        model_reset();
        #3;
        check_eq("reset_po", 32'(SYS_PORESETn), 0);
        check_eq("reset_h", 32'(SYS_HRESETn), 0);
        check_eq("reset_state", 32'(RST_STATE), 0);
        check_eq("reset_cause", 32'(RST_CAUSE), 0);

        // Power-on with defaults.
        PORESETn = 1'b1;
        edge_n   = 0;
        for (int i = 0; i < 60 && !SYS_PORESETn; i++) step();
        check_eq("por_po_rise_edge", edge_n, 19);
        for (int i = 0; i < 60 && !SYS_HRESETn; i++) step();
        check_eq("por_h_rise_edge", edge_n, 23);
        check_eq("por_state_run", 32'(RST_STATE), 3);
        check_eq("por_cause", 32'(RST_CAUSE), 0);
        repeat (3) step();

        // Software reset pulse.
        low_cnt    = 0;
        SWRESETREQ = 1'b1;
        step();
        if (!SYS_HRESETn) low_cnt++;
        SWRESETREQ = 1'b0;
        repeat (25) begin
            step();
            if (!SYS_HRESETn) low_cnt++;
        end
        check_eq("sw_pulse_low_cycles", low_cnt, 16);
        check_eq("sw_pulse_po_high", 32'(SYS_PORESETn), 1);
        check_eq("sw_pulse_cause", 32'(RST_CAUSE), 2);

        // Held software request.
        low_cnt    = 0;
        SWRESETREQ = 1'b1;
        repeat (40) begin
            step();
            if (!SYS_HRESETn) low_cnt++;
        end
        SWRESETREQ = 1'b0;
        step();
        check_eq("sw_held_low_cycles", low_cnt, 40);
        check_eq("sw_held_run_after_drop", 32'(RST_STATE), 3);
        check_eq("sw_held_h_after_drop", 32'(SYS_HRESETn), 1);
        repeat (3) step();

        // Brown-out during SW_RST.
        SWRESETREQ = 1'b1;
        step();
        SWRESETREQ = 1'b0;
        repeat (3) step();
        SUPPLY_OK = 1'b0;
        k = 0;
        while (k < 10 && (SYS_PORESETn || SYS_HRESETn)) begin
            step();
            k++;
        end
        check_eq("brownout_edges", k, 3);
        check_eq("brownout_cause", 32'(RST_CAUSE), 1);
        repeat (10 - k) step();
        check_eq("brownout_state_wait", 32'(RST_STATE), 0);
        SUPPLY_OK = 1'b1;
        repeat (30) step();
        check_eq("brownout_rerun_run", 32'(RST_STATE), 3);
        check_eq("brownout_rerun_cause", 32'(RST_CAUSE), 1);

        // Second brown-out to reach REL_PO, then async pad reset between edges.
        SUPPLY_OK = 1'b0;
        repeat (5) step();
        SUPPLY_OK = 1'b1;
        for (int i = 0; i < 60 && RST_STATE != 3'd2; i++) step();
        check_eq("async_in_relpo", 32'(RST_STATE), 2);
        #3;
        assert_por();
        #2;
        check_eq("async_po", 32'(SYS_PORESETn), 0);
        check_eq("async_h", 32'(SYS_HRESETn), 0);
        check_eq("async_state", 32'(RST_STATE), 0);
        check_eq("async_cause", 32'(RST_CAUSE), 0);

        // Late supply.
        SUPPLY_OK = 1'b0;
        step();
        PORESETn = 1'b1;
        repeat (50) step();
        check_eq("late_wait_state", 32'(RST_STATE), 0);
        SUPPLY_OK = 1'b1;
        edge_n    = 0;
        for (int i = 0; i < 60 && !SYS_PORESETn; i++) step();
        check_eq("late_po_rise_edge", edge_n, 19);
        for (int i = 0; i < 60 && !SYS_HRESETn; i++) step();
        check_eq("late_h_rise_edge", edge_n, 23);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (PORESETn && r < 2) assert_por();
            else if (!PORESETn && r < 40) PORESETn = 1'b1;
            if (r >= 95) SUPPLY_OK = ~SUPPLY_OK;
            else if (!SUPPLY_OK && r >= 70) SUPPLY_OK = 1'b1;
            if ($urandom_range(0, 7) == 0) SWRESETREQ = ~SWRESETREQ;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
